// File: rtl/c1_scratchpad.sv
// C1 bus scratchpad: 2^ADDR_W-byte little-endian memory that answers C1 requests LATENCY cycles
// after the last request beat. Define C1_SCRATCHPAD_STATS_EN to build the read/write counters.
module c1_scratchpad #(
    parameter int ADDR_W   = 19,
    parameter int OFFSET_W = 4,
    parameter int LATENCY  = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dump,
    input  logic [15:0] addr_w,
    inout  wire  [15:0] data_w,
    inout  wire  [2:0]  cmd_w,
    output logic [31:0] total_reads,
    output logic [31:0] total_writes
);

    localparam int          HI_W  = ADDR_W - OFFSET_W;
    localparam int          CNT_W = $clog2(LATENCY + 1);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    localparam logic [2:0] CMD_NOP      = 3'd0;
    localparam logic [2:0] CMD_READ8    = 3'd1;
    localparam logic [2:0] CMD_READ16   = 3'd2;
    localparam logic [2:0] CMD_READ32   = 3'd3;
    localparam logic [2:0] CMD_INVAL    = 3'd4;
    localparam logic [2:0] CMD_WRITE8   = 3'd5;
    localparam logic [2:0] CMD_WRITE16  = 3'd6;
    localparam logic [2:0] CMD_WRITE32  = 3'd7;
    localparam logic [2:0] CMD_RESPONSE = 3'd7;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR2  = 3'd1;
    localparam logic [2:0] S_WDATA2 = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_RESP1  = 3'd4;
    localparam logic [2:0] S_RESP2  = 3'd5;

    if (LATENCY < 2) begin : g_bad_latency
        $error("c1_scratchpad: LATENCY must be at least 2");
    end
    if (HI_W < 1 || HI_W > 16 || OFFSET_W < 1 || OFFSET_W > 16) begin : g_bad_addr
        $error("c1_scratchpad: address split does not fit the 16-bit address bus");
    end

    logic [2:0]        state_q, state_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       resp_q, resp_d;
    logic              cmd_oe_q, cmd_oe_d;
    logic              data_oe_q, data_oe_d;
    logic [7:0]        mem_q [DEPTH];

    logic [ADDR_W-1:0] a1, a2, a3;
    logic              req_valid;
    logic              is_write;
    logic              enter_resp;
    logic              unused_addr_bits;

    assign a1 = addr_q + ADDR_W'(1);
    assign a2 = addr_q + ADDR_W'(2);
    assign a3 = addr_q + ADDR_W'(3);
    assign is_write   = (cmd_q == CMD_WRITE8) || (cmd_q == CMD_WRITE16) || (cmd_q == CMD_WRITE32);
    assign enter_resp = (state_q == S_WAIT) && (cnt_q == CNT_W'(LATENCY));
    assign unused_addr_bits = ^addr_w;

    // case-equality matching makes X/Z on the command bus fall through to "no request"
    always_comb begin
        case (cmd_w)
            3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7: req_valid = 1'b1;
            default:                                  req_valid = 1'b0;
        endcase
    end

    assign cmd_w  = cmd_oe_q  ? CMD_RESPONSE : 3'bz;
    assign data_w = data_oe_q ? resp_q       : 16'bz;

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        resp_d    = resp_q;
        cmd_oe_d  = cmd_oe_q;
        data_oe_d = data_oe_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    cmd_d                      = cmd_w;
                    addr_d[ADDR_W-1:OFFSET_W]  = addr_w[HI_W-1:0];
                    state_d                    = S_ADDR2;
                end
            end
            S_ADDR2: begin
                addr_d[OFFSET_W-1:0] = addr_w[OFFSET_W-1:0];
                if (is_write) begin
                    wdata_d[15:0] = data_w;
                end
                cnt_d   = CNT_W'(1);
                state_d = (cmd_q == CMD_WRITE32) ? S_WDATA2 : S_WAIT;
            end
            S_WDATA2: begin
                wdata_d[31:16] = data_w;
                cnt_d          = CNT_W'(1);
                state_d        = S_WAIT;
            end
            S_WAIT: begin
                if (enter_resp) begin
                    state_d   = S_RESP1;
                    cmd_oe_d  = 1'b1;
                    data_oe_d = (cmd_q != CMD_INVAL);
                    case (cmd_q)
                        CMD_READ8:              resp_d = {8'h00, mem_q[addr_q]};
                        CMD_READ16, CMD_READ32: resp_d = {mem_q[a1], mem_q[addr_q]};
                        default:                resp_d = '0;
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP1: begin
                if (cmd_q == CMD_READ32) begin
                    state_d = S_RESP2;
                    resp_d  = {mem_q[a3], mem_q[a2]};
                end else begin
                    state_d   = S_IDLE;
                    cmd_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                cmd_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cmd_q     <= CMD_NOP;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            resp_q    <= '0;
            cmd_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            mem_q     <= '{default: 8'h00};
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            resp_q    <= resp_d;
            cmd_oe_q  <= cmd_oe_d;
            data_oe_q <= data_oe_d;
            // storage commits on the same edge that first drives RESPONSE
            if (enter_resp) begin
                case (cmd_q)
                    CMD_WRITE8: begin
                        mem_q[addr_q] <= wdata_q[7:0];
                    end
                    CMD_WRITE16: begin
                        mem_q[addr_q] <= wdata_q[7:0];
                        mem_q[a1]     <= wdata_q[15:8];
                    end
                    CMD_WRITE32: begin
                        mem_q[addr_q] <= wdata_q[7:0];
                        mem_q[a1]     <= wdata_q[15:8];
                        mem_q[a2]     <= wdata_q[23:16];
                        mem_q[a3]     <= wdata_q[31:24];
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef C1_SCRATCHPAD_STATS_EN
    logic [31:0] reads_q, reads_d;
    logic [31:0] writes_q, writes_d;

    always_comb begin
        reads_d  = reads_q;
        writes_d = writes_q;
        if (enter_resp) begin
            if ((cmd_q == CMD_READ8) || (cmd_q == CMD_READ16) || (cmd_q == CMD_READ32)) begin
                reads_d = reads_q + 32'd1;
            end
            if (is_write) begin
                writes_d = writes_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reads_q  <= '0;
            writes_q <= '0;
        end else begin
            reads_q  <= reads_d;
            writes_q <= writes_d;
        end
    end

    assign total_reads  = reads_q;
    assign total_writes = writes_q;
`else
    assign total_reads  = '0;
    assign total_writes = '0;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (dump && !reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (mem_q[ADDR_W'(i)] != 8'h00) begin
                    $display("%05h: %02h", ADDR_W'(i), mem_q[ADDR_W'(i)]);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_c1_scratchpad.sv
// Directed bench for c1_scratchpad: vector table of C1 transactions plus reset/stray-request sequences.
module tb_c1_scratchpad;

    localparam int LAT = 6;

    localparam logic [2:0] RD8  = 3'd1;
    localparam logic [2:0] RD16 = 3'd2;
    localparam logic [2:0] RD32 = 3'd3;
    localparam logic [2:0] INV  = 3'd4;
    localparam logic [2:0] WR8  = 3'd5;
    localparam logic [2:0] WR16 = 3'd6;
    localparam logic [2:0] WR32 = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic        dump;
    logic [15:0] addr_w;
    tri0  [2:0]  cmd_w;
    tri1  [15:0] data_w;
    logic [2:0]  cmd_drv;
    logic        cmd_oe;
    logic [15:0] data_drv;
    logic        data_oe;
    logic [31:0] total_reads;
    logic [31:0] total_writes;

    int checks = 0;
    int errors = 0;

    assign cmd_w  = cmd_oe  ? cmd_drv  : 3'bz;
    assign data_w = data_oe ? data_drv : 16'bz;

    always #5 clk = ~clk;

    c1_scratchpad #(.ADDR_W(19), .OFFSET_W(4), .LATENCY(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .dump         (dump),
        .addr_w       (addr_w),
        .data_w       (data_w),
        .cmd_w        (cmd_w),
        .total_reads  (total_reads),
        .total_writes (total_writes)
    );

    typedef struct {
        logic [2:0]  cmd;
        logic [18:0] addr;
        logic [31:0] wdata;
        logic [15:0] exp_lo;
        logic [15:0] exp_hi;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Undriven cmd_w reads 0 (pulldown) and undriven data_w reads FFFF (pullup).
    task automatic txn(input string name, input logic [2:0] cmd, input logic [18:0] addr,
                       input logic [31:0] wdata, input logic [15:0] exp_lo,
                       input logic [15:0] exp_hi, input bit stray);
        int  k;
        bit  found;
        bit  wr;
        wr       = (cmd == WR8) || (cmd == WR16) || (cmd == WR32);
        cmd_drv  = cmd;
        cmd_oe   = 1'b1;
        addr_w   = {1'b0, addr[18:4]};
        data_oe  = 1'b0;
        step();
        cmd_oe   = 1'b0;
        addr_w   = {12'h000, addr[3:0]};
        data_drv = wdata[15:0];
        data_oe  = wr;
        #1;
        check({name, ":p0_cmd"}, cmd_w, 3'd0);
        if (!wr) check({name, ":p0_data"}, data_w, 16'hFFFF);
        step();
        if (cmd == WR32) begin
            data_drv = wdata[31:16];
            step();
        end
        data_oe = 1'b0;
        #1;
        check({name, ":pl_cmd"}, cmd_w, 3'd0);
        found = 1'b0;
        for (k = 1; k <= LAT + 4; k++) begin
            step();
            cmd_oe = 1'b0;
            #1;
            if (cmd_w == 3'd7) begin
                found = 1'b1;
                break;
            end
            check({name, ":wait_cmd"}, cmd_w, 3'd0);
            check({name, ":wait_data"}, data_w, 16'hFFFF);
            if (stray && k == 2) begin
                cmd_drv = WR8;
                addr_w  = 16'h0001;
                cmd_oe  = 1'b1;
            end
        end
        check({name, ":latency"}, found ? k : 0, LAT);
        if (!found) return;
        if (!wr) check({name, ":resp_lo"}, data_w, exp_lo);
        step();
        #1;
        if (cmd == RD32) begin
            check({name, ":resp2_cmd"}, cmd_w, 3'd7);
            check({name, ":resp_hi"}, data_w, exp_hi);
            step();
            #1;
        end
        check({name, ":rel_cmd"}, cmd_w, 3'd0);
        check({name, ":rel_data"}, data_w, 16'hFFFF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{WR8,  19'h00010, 32'h000000A5, 16'h0000, 16'h0000};
        vecs[1]  = '{RD8,  19'h00010, 32'h0,        16'h00A5, 16'h0000};
        vecs[2]  = '{WR32, 19'h7FFFE, 32'hDEADBEEF, 16'h0000, 16'h0000};
        vecs[3]  = '{RD32, 19'h7FFFE, 32'h0,        16'hBEEF, 16'hDEAD};
        vecs[4]  = '{RD8,  19'h00000, 32'h0,        16'h00AD, 16'h0000};
        vecs[5]  = '{RD16, 19'h7FFFF, 32'h0,        16'hADBE, 16'h0000};
        vecs[6]  = '{WR16, 19'h00003, 32'h00001234, 16'h0000, 16'h0000};
        vecs[7]  = '{RD16, 19'h00003, 32'h0,        16'h1234, 16'h0000};
        vecs[8]  = '{RD8,  19'h00004, 32'h0,        16'h0012, 16'h0000};
        vecs[9]  = '{INV,  19'h00040, 32'h0,        16'hFFFF, 16'h0000};
        vecs[10] = '{RD16, 19'h00040, 32'h0,        16'h0000, 16'h0000};
        vecs[11] = '{WR8,  19'h00011, 32'h0000FF77, 16'h0000, 16'h0000};
        vecs[12] = '{RD16, 19'h00010, 32'h0,        16'h77A5, 16'h0000};
        vecs[13] = '{RD32, 19'h00001, 32'h0,        16'h00DE, 16'h1234};

        reset    = 1'b1;
        dump     = 1'b0;
        addr_w   = '0;
        cmd_drv  = '0;
        cmd_oe   = 1'b0;
        data_drv = '0;
        data_oe  = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_cmd", cmd_w, 3'd0);
        check("rst_data", data_w, 16'hFFFF);
        check("rst_reads", total_reads, 32'd0);
        check("rst_writes", total_writes, 32'd0);

        for (int i = 0; i < 14; i++) begin
            txn($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_lo, vecs[i].exp_hi, 1'b0);
        end
`ifdef C1_SCRATCHPAD_STATS_EN
        check("tbl_reads", total_reads, 32'd9);
        check("tbl_writes", total_writes, 32'd4);
`else
        check("tbl_reads", total_reads, 32'd0);
        check("tbl_writes", total_writes, 32'd0);
`endif

        // A request pulse during WAIT must be ignored entirely.
        txn("stray", RD8, 19'h00010, 32'h0, 16'h00A5, 16'h0000, 1'b1);
        for (int i = 0; i < LAT + 4; i++) begin
            step();
            #1;
            check("stray_idle_cmd", cmd_w, 3'd0);
        end
        txn("stray_chk", RD8, 19'h00010, 32'h0, 16'h00A5, 16'h0000, 1'b0);

        // Reset in WAIT of a WRITE16: no response, no write, storage cleared.
        cmd_drv = WR16;
        cmd_oe  = 1'b1;
        addr_w  = 16'h0002;
        step();
        cmd_oe   = 1'b0;
        addr_w   = 16'h0000;
        data_drv = 16'hBEEF;
        data_oe  = 1'b1;
        step();
        data_oe = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("rstw_cmd", cmd_w, 3'd0);
        check("rstw_data", data_w, 16'hFFFF);
        for (int i = 0; i < LAT + 4; i++) begin
            step();
            #1;
            check("rstw_noresp", cmd_w, 3'd0);
        end
        txn("rstw_rd20", RD16, 19'h00020, 32'h0, 16'h0000, 16'h0000, 1'b0);
        txn("rstw_rd10", RD8,  19'h00010, 32'h0, 16'h0000, 16'h0000, 1'b0);
        txn("cnt_w1", WR8,  19'h00030, 32'h00000011, 16'h0, 16'h0, 1'b0);
        txn("cnt_w2", WR16, 19'h00032, 32'h00002233, 16'h0, 16'h0, 1'b0);
        txn("cnt_w3", WR32, 19'h00034, 32'h44556677, 16'h0, 16'h0, 1'b0);
`ifdef C1_SCRATCHPAD_STATS_EN
        check("cnt_reads", total_reads, 32'd2);
        check("cnt_writes", total_writes, 32'd3);
`else
        check("cnt_reads", total_reads, 32'd0);
        check("cnt_writes", total_writes, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/c1_scratchpad.md
C1_SCRATCHPAD -- requirements
Module: c1_scratchpad

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, byte-address width (tag+set+offset = 10+5+4).
REQ-002 SHALL have parameter OFFSET_W, default 4, low address bits carried in the second address beat.
REQ-003 SHALL have parameter LATENCY, default 6, cycles from the last request beat to the first response beat; values below 2 SHALL be an elaboration error.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-006 SHALL have port dump  input  1  on posedge with dump=1, print every nonzero byte as "addr: data" via $display.
REQ-007 SHALL have port addr_w  input  16  C1 address bus: beat 1 carries addr[ADDR_W-1:OFFSET_W], beat 2 carries addr[OFFSET_W-1:0].
REQ-008 SHALL have port data_w  inout  16  C1 data bus, driven only while responding, else high-Z.
REQ-009 SHALL have port cmd_w  inout  3  C1 command bus, driven only while responding, else high-Z.
REQ-010 SHALL have ports total_reads, total_writes  output  32  each a completed-transaction counter.

Function
REQ-011 Command codes SHALL be NOP=0, READ8=1, READ16=2, READ32=3, INVALIDATE_LINE=4, WRITE8=5, WRITE16=6, WRITE32=7, RESPONSE=7.
REQ-012 Storage SHALL be 2^ADDR_W bytes; byte order little-endian; all address arithmetic SHALL wrap modulo 2^ADDR_W; misaligned accesses SHALL be legal.
REQ-013 FSM states SHALL be IDLE, ADDR2, WDATA2, WAIT, RESP1, RESP2.
REQ-014 In IDLE, a posedge with cmd_w not NOP (X/Z treated as NOP) SHALL latch cmd and high address bits and go to ADDR2; this posedge is P0.
REQ-015 In ADDR2 (P1), the offset SHALL be latched; for WRITE8/16/32, data_w SHALL also be latched as beat 0; WRITE32 goes to WDATA2, all others to WAIT.
REQ-016 In WDATA2 (P2), data_w SHALL be latched as beat 1 (bytes addr+2, addr+3); next state WAIT.
REQ-017 In WAIT, with PL = last latching posedge, the block SHALL drive cmd_w=RESPONSE and data_w starting at posedge PL+LATENCY and enter RESP1.
REQ-018 The storage write SHALL commit at the posedge RESPONSE is first driven: WRITE8 writes data[7:0]; WRITE16 writes 2 bytes; WRITE32 writes 4 bytes.
REQ-019 READ8 SHALL return {8'h00, byte}; READ16 SHALL return {byte[a+1], byte[a]}; READ32 SHALL return the low half in RESP1 and the high half in RESP2.
REQ-020 RESP1 SHALL last one cycle; READ32 then goes to RESP2 for one more cycle with RESPONSE held; the bus SHALL be released to high-Z at the next posedge, followed by a return to IDLE.
REQ-021 INVALIDATE_LINE SHALL be acknowledged with a single RESPONSE beat, data_w undriven, and no storage change.
REQ-022 Bus activity outside IDLE SHALL be ignored; a request arriving in the same cycle as release SHALL be sampled no earlier than the first posedge in IDLE.
REQ-023 total_reads SHALL increment on RESP1 for READ*; total_writes SHALL increment on RESP1 for WRITE*; both SHALL wrap at 2^32.

Reset
REQ-024 On posedge with reset=1: state IDLE, cmd_w/data_w high-Z in the same cycle, counters 0, all storage bytes 0; any in-flight transaction SHALL be dropped without a storage write.
REQ-025 Reset SHALL take priority over dump and over any bus request in the same cycle.

Configuration
REQ-026 With macro C1_SCRATCHPAD_STATS_EN defined, counters SHALL behave per REQ-023; without it, total_reads and total_writes SHALL be constant 0 and the counter logic SHALL be absent.

Verification
REQ-027 Reset, then WRITE8 at 0x00010 data 0xA5 -> RESPONSE at P1+6; READ8 at 0x00010 -> data_w=0x00A5.
REQ-028 WRITE32 at 0x7FFFE data 0xDEADBEEF -> bytes 0x7FFFE=EF, 0x7FFFF=BE, 0x00000=AD, 0x00001=DE (wrap); READ32 at 0x7FFFE -> beats 0xBEEF then 0xDEAD on consecutive posedges.
REQ-029 READ16 at 0x00003 after WRITE16 at 0x00003 data 0x1234 -> 0x1234; cmd_w and data_w high-Z at P0, P1 and on every cycle before response and after release.
REQ-030 Reset asserted during WAIT of WRITE16 at 0x00020 -> no RESPONSE, bus high-Z; a following READ16 at 0x00020 returns 0x0000.
REQ-031 INVALIDATE_LINE at 0x00040 -> one RESPONSE beat, storage unchanged; with C1_SCRATCHPAD_STATS_EN after 2 reads and 3 writes -> total_reads=2, total_writes=3; without the macro -> both 0.
